max_collector: RTL
==================

MAX_COLLECTOR -- requirements
Module: max_collector

Interface
REQ-001 Parameter: DEPTH, default 8, number of buffered window maxima; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 done_in  input  1  window-complete flag from the upstream max finder; level, stays high until next window starts.
REQ-005 max_in  input  8  upstream window maximum, unsigned, valid while done_in high.
REQ-006 out_data  output  8  oldest buffered maximum.
REQ-007 out_valid  output  1  high when out_data holds a buffered entry.
REQ-008 out_ready  input  1  consumer accepts out_data when high together with out_valid.
REQ-009 count  output  5  number of buffered entries, 0..DEPTH.
REQ-010 overflow  output  1  sticky flag: at least one capture dropped because the buffer was full.
REQ-011 peak  output  8  largest max_in captured since reset (see Configuration).

Function
REQ-012 Block SHALL register done_in into done_d each cycle; capture event = done_in & ~done_d.
REQ-013 On a capture event, max_in SHALL be written at the write pointer; exactly one capture per done_in high period, however long it lasts.
REQ-014 Buffer SHALL be a circular FIFO, pointers log2(DEPTH) bits, wrapping from DEPTH-1 to 0 with no gap.
REQ-015 Pop = out_valid & out_ready; read pointer advances one entry per pop.
REQ-016 out_valid SHALL equal (count != 0); out_data SHALL be the entry at the read pointer; out_data is don't-care while out_valid is low.
REQ-017 Latency: capture event in cycle N -> entry visible (out_valid high if buffer was empty) in cycle N+1; no same-cycle fall-through.
REQ-018 out_data/out_valid SHALL stay stable while out_valid & ~out_ready.
REQ-019 Capture and pop in the same cycle: both occur, count unchanged.
REQ-020 Capture when count==DEPTH without a pop: value dropped, pointers and count unchanged, overflow set to 1 in next cycle.
REQ-021 Capture when count==DEPTH with a simultaneous pop: capture accepted, overflow unchanged.
REQ-022 Pop when empty is impossible (out_valid low); out_ready alone SHALL change nothing.
REQ-023 overflow SHALL remain 1 until reset.
REQ-024 count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-025 On reset: count=0, pointers=0, out_valid=0, overflow=0, peak=0, done_d=0; buffer contents need not be cleared.
REQ-026 Reset SHALL override any simultaneous capture or pop; reset mid-operation discards all buffered entries.
REQ-027 done_in high in the first cycle after reset deasserts SHALL count as a capture event (done_d cleared by reset).

Configuration
REQ-028 Macro MAX_COLLECTOR_PEAK_EN: when defined, peak SHALL update in cycle N+1 to max(peak, max_in) on every capture event at cycle N, including dropped captures.
REQ-029 Without MAX_COLLECTOR_PEAK_EN, peak SHALL be constant 0 and no peak register SHALL be synthesised; all other behaviour identical.

Verification
REQ-030 Reset, then done_in high 5 cycles with max_in=0x3C, out_ready=0 -> one entry, count=1, out_data=0x3C, out_valid high from cycle after first done_in high.
REQ-031 Captures 0x10,0x20,0x30 with out_ready=0, then out_ready=1 for 3 cycles -> out_data 0x10,0x20,0x30 in order, count 3->0, out_valid low afterwards.
REQ-032 DEPTH=8, out_ready=0, 9 captures 0x01..0x09 -> count=8, overflow=1, pops yield 0x01..0x08; 0x09 lost.
REQ-033 Buffer full, capture 0xAA in the same cycle as a pop -> count stays 8, overflow stays 0, 0xAA is the last entry read.
REQ-034 12 captures/pops alternating across pointer wrap -> all values returned in order; with MAX_COLLECTOR_PEAK_EN, captures 0x40,0xF0,0x80 -> peak=0xF0; without it peak=0.
REQ-035 Reset asserted with count=3 and a capture pending -> next cycle count=0, out_valid=0, overflow=0, peak=0.

Source files
------------

// File: rtl/max_collector_if.sv
// Handshake bundle for max_collector: upstream window-max capture side, consumer
// pop side and status. The slave modport is the collector, master drives it.
interface max_collector_if;
  logic       done_in;
  logic [7:0] max_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] peak;

  modport slave (
    input  done_in,
    input  max_in,
    input  out_ready,
    output out_data,
    output out_valid,
    output count,
    output overflow,
    output peak
  );

  modport master (
    output done_in,
    output max_in,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  count,
    input  overflow,
    input  peak
  );
endinterface

// File: rtl/max_collector.sv
// Buffers one window maximum per rising edge of done_in in a circular FIFO.
// Optional running peak tracker is enabled by defining MAX_COLLECTOR_PEAK_EN.
module max_collector #(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  max_collector_if.slave  bus
);
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    cnt;
  logic          done_d;
  logic          ovf;

  logic capture;
  logic pop;
  logic full;
  logic accept;

  assign capture = bus.done_in & ~done_d;
  assign pop     = (cnt != 5'd0) & bus.out_ready;
  assign full    = (cnt == DEPTH_C);
  // A full buffer still takes a capture if an entry leaves in the same cycle.
  assign accept  = capture & (~full | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      done_d <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= 5'd0;
      ovf    <= 1'b0;
    end else begin
      done_d <= bus.done_in;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
      if (capture && full && !pop) ovf <= 1'b1;
    end
  end

  // Storage is not reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (!reset && accept) mem[wr_ptr] <= bus.max_in;
  end

  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_valid = (cnt != 5'd0);
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;

`ifdef MAX_COLLECTOR_PEAK_EN
  logic [7:0] peak_q;

  // Dropped captures still contribute to the peak.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q <= 8'h00;
    end else if (capture && (bus.max_in > peak_q)) begin
      peak_q <= bus.max_in;
    end
  end

  assign bus.peak = peak_q;
`else
  assign bus.peak = 8'h00;
`endif
endmodule
